divider_seq: RTL

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/divider_seq.sv
// divider_seq: sequential unsigned restoring divider, one quotient bit per cycle.
// Optional feature macro: DIVIDER_SEQ_DBZ_EN -- when defined, a start with b=0
// skips the iteration sequence and reports divide-by-zero directly; when
// undefined, dbz is tied to 0 and b=0 runs the normal WIDTH-cycle path.
module divider_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] dvd_q,   dvd_d;
    logic [WIDTH-1:0] dvs_q,   dvs_d;
    logic [WIDTH:0]   rem_q,   rem_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic [WIDTH-1:0] r_q,     r_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
`ifdef DIVIDER_SEQ_DBZ_EN
    logic             dbz_q,   dbz_d;
`endif

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             qbit;

    // One restoring step: shift next dividend bit into the remainder, trial-subtract.
    always_comb begin
        rem_sh  = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
        qbit    = (rem_sh >= {1'b0, dvs_q});
        rem_sub = qbit ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef DIVIDER_SEQ_DBZ_EN
        dbz_d   = dbz_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = a;
                    dvs_d = b;
                    cnt_d = '0;
                    rem_d = '0;
`ifdef DIVIDER_SEQ_DBZ_EN
                    if (b == '0) begin
                        state_d = DONE;
                        q_d     = '1;
                        r_d     = a;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
`else
                    state_d = RUN;
                    busy_d  = 1'b1;
`endif
                end
            end
            RUN: begin
                rem_d = rem_sub;
                dvd_d = {dvd_q[WIDTH-2:0], qbit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_d     = {dvd_q[WIDTH-2:0], qbit};
                    r_d     = rem_sub[WIDTH-1:0];
`ifdef DIVIDER_SEQ_DBZ_EN
                    dbz_d   = 1'b0;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIVIDER_SEQ_DBZ_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIVIDER_SEQ_DBZ_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
`ifdef DIVIDER_SEQ_DBZ_EN
    assign dbz  = dbz_q;
`else
    assign dbz  = 1'b0;
`endif

endmodule
